// File: rtl/multi_alarm_timekeeper.sv
`default_nettype none
// ============================================================================
// Module   : multi_alarm_timekeeper
// Purpose  : 24-hour BCD time-of-day core with ALARM_N alarm channels,
//            per-channel snooze/auto-stop and optional hourly chime
//            (enabled by defining HOURLY_CHIME_EN).
// Revision : 1.0
// ============================================================================
module multi_alarm_timekeeper #(
  parameter int ALARM_N  = 4,
  parameter int RING_S   = 30,
  parameter int SNOOZE_M = 5
) (
  input  logic                             CP,
  input  logic                             CR,
  input  logic                             TICK,
  input  logic                             SET_EN,
  input  logic [$clog2(ALARM_N+1)-1:0]     SEL,
  input  logic                             H_UP,
  input  logic                             H_DOWN,
  input  logic                             M_UP,
  input  logic                             M_DOWN,
  input  logic                             S_CLR,
  input  logic [ALARM_N-1:0]               AL_ON,
  input  logic                             STOP,
  input  logic                             SNOOZE,
  output logic [7:0]                       Q_H,
  output logic [7:0]                       Q_M,
  output logic [7:0]                       Q_S,
  output logic [7:0]                       A_H,
  output logic [7:0]                       A_M,
  output logic [ALARM_N-1:0]               RING,
  output logic                             ALARM,
  output logic                             TC_D,
  output logic                             CHIME
);

  localparam int SEL_W = $clog2(ALARM_N+1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } ch_state_t;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)          return 8'h00;
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)        return max;
    if (v[3:0] == 4'd0)    return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Opposing buttons in the same cycle cancel out.
  function automatic logic [7:0] bcd_adj(input logic [7:0] v, input logic up,
                                         input logic dn, input logic [7:0] max);
    if (up && !dn) return bcd_inc(v, max);
    if (dn && !up) return bcd_dec(v, max);
    return v;
  endfunction

  logic [7:0] h_q, m_q, s_q;
  logic [7:0] h_d, m_d, s_d;
  logic       tcd_q;
  logic [7:0] ah_q, am_q, ah_d, am_d;
  logic [ALARM_N-1:0][7:0] alh_q, alm_q, alh_d, alm_d;

  logic w_tset, w_adv, w_wrap, w_new_min;
  assign w_tset    = SET_EN && (SEL == '0);
  assign w_adv     = TICK && !w_tset;
  assign w_wrap    = w_adv && (h_q == 8'h23) && (m_q == 8'h59) && (s_q == 8'h59);
  assign w_new_min = w_adv && (s_q == 8'h59);

  always_comb begin
    h_d = h_q;
    m_d = m_q;
    s_d = s_q;
    if (w_tset) begin
      h_d = bcd_adj(h_q, H_UP, H_DOWN, 8'h23);
      m_d = bcd_adj(m_q, M_UP, M_DOWN, 8'h59);
      if (S_CLR) s_d = 8'h00;
    end else if (w_adv) begin
      s_d = bcd_inc(s_q, 8'h59);
      if (s_q == 8'h59) begin
        m_d = bcd_inc(m_q, 8'h59);
        if (m_q == 8'h59) h_d = bcd_inc(h_q, 8'h23);
      end
    end
  end

  always_comb begin
    alh_d = alh_q;
    alm_d = alm_q;
    for (int k = 0; k < ALARM_N; k++) begin
      if (SET_EN && (SEL == SEL_W'(k + 1))) begin
        alh_d[k] = bcd_adj(alh_q[k], H_UP, H_DOWN, 8'h23);
        alm_d[k] = bcd_adj(alm_q[k], M_UP, M_DOWN, 8'h59);
      end
    end
  end

  // Readback uses the next alarm value so edits show after one cycle.
  always_comb begin
    ah_d = 8'h00;
    am_d = 8'h00;
    for (int k = 0; k < ALARM_N; k++) begin
      if (SEL == SEL_W'(k + 1)) begin
        ah_d = alh_d[k];
        am_d = alm_d[k];
      end
    end
  end

  always_ff @(posedge CP) begin
    if (!CR) begin
      h_q   <= 8'h00;
      m_q   <= 8'h00;
      s_q   <= 8'h00;
      tcd_q <= 1'b0;
      ah_q  <= 8'h00;
      am_q  <= 8'h00;
      alh_q <= '0;
      alm_q <= '0;
    end else begin
      h_q   <= h_d;
      m_q   <= m_d;
      s_q   <= s_d;
      tcd_q <= w_wrap;
      ah_q  <= ah_d;
      am_q  <= am_d;
      alh_q <= alh_d;
      alm_q <= alm_d;
    end
  end

  // Snooze target: current HH:MM plus SNOOZE_M minutes, carrying into the hour.
  logic [6:0] w_min_bin, w_min_sum, w_min_t;
  logic       w_min_cy;
  logic [7:0] w_snz_h, w_snz_m;
  assign w_min_bin = 7'(m_q[7:4]) * 7'd10 + 7'(m_q[3:0]);
  assign w_min_sum = w_min_bin + 7'(SNOOZE_M);
  assign w_min_cy  = (w_min_sum >= 7'd60);
  assign w_min_t   = w_min_cy ? (w_min_sum - 7'd60) : w_min_sum;
  assign w_snz_m   = {4'(w_min_t / 7'd10), 4'(w_min_t % 7'd10)};
  assign w_snz_h   = w_min_cy ? bcd_inc(h_q, 8'h23) : h_q;

  generate
    for (genvar k = 0; k < ALARM_N; k++) begin : g_ch
      ch_state_t  st_q, st_d;
      logic [7:0] cnt_q, cnt_d;
      logic [7:0] snh_q, snh_d, snm_q, snm_d;

      always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        snh_d = snh_q;
        snm_d = snm_q;
        case (st_q)
          ST_IDLE: begin
            if (w_new_min && (h_d == alh_q[k]) && (m_d == alm_q[k])) begin
              st_d  = ST_RINGING;
              cnt_d = 8'd0;
            end
          end
          ST_RINGING: begin
            if (STOP) begin
              st_d = ST_IDLE;
            end else if (SNOOZE) begin
              st_d  = ST_SNOOZED;
              snh_d = w_snz_h;
              snm_d = w_snz_m;
            end else if (TICK) begin
              if (cnt_q == 8'(RING_S - 1)) st_d = ST_IDLE;
              else                         cnt_d = cnt_q + 8'd1;
            end
          end
          ST_SNOOZED: begin
            if (STOP) begin
              st_d = ST_IDLE;
            end else if (w_new_min && (h_d == snh_q) && (m_d == snm_q)) begin
              st_d  = ST_RINGING;
              cnt_d = 8'd0;
            end
          end
          default: st_d = ST_IDLE;
        endcase
        // Disarming wins over every other transition.
        if (!AL_ON[k]) begin
          st_d  = ST_IDLE;
          cnt_d = 8'd0;
        end
      end

      always_ff @(posedge CP) begin
        if (!CR) begin
          st_q  <= ST_IDLE;
          cnt_q <= 8'd0;
          snh_q <= 8'h00;
          snm_q <= 8'h00;
        end else begin
          st_q  <= st_d;
          cnt_q <= cnt_d;
          snh_q <= snh_d;
          snm_q <= snm_d;
        end
      end

      assign RING[k] = (st_q == ST_RINGING);
    end
  endgenerate

`ifdef HOURLY_CHIME_EN
  logic chime_q;
  always_ff @(posedge CP) begin
    if (!CR) chime_q <= 1'b0;
    else     chime_q <= !SET_EN && (((m_d == 8'h59) && (s_d >= 8'h55)) ||
                                    ((m_d == 8'h00) && (s_d == 8'h00)));
  end
  assign CHIME = chime_q;
`else
  assign CHIME = 1'b0;
`endif

  assign Q_H   = h_q;
  assign Q_M   = m_q;
  assign Q_S   = s_q;
  assign A_H   = ah_q;
  assign A_M   = am_q;
  assign TC_D  = tcd_q;
  assign ALARM = |RING;

endmodule
`default_nettype wire

// File: doc/multi_alarm_timekeeper.md
# multi_alarm_timekeeper

Parametrised 24-hour BCD time-of-day core with ALARM_N independent alarm channels, per-channel snooze and auto-timeout, and hourly chime. It replaces the separate timer/timing pair in the clock top. It is driven by the 1 Hz enable from the frequency divider and feeds the print and chronopher blocks with BCD time, alarm readback and ring status.

## Interface
Parameters:
- ALARM_N, 4, number of alarm channels (1..8)
- RING_S, 30, ring duration in seconds before auto-stop (1..255)
- SNOOZE_M, 5, snooze interval in minutes (1..59)

Ports:
- CP  in  1  clock; the only clock, all state on rising edge
- CR  in  1  reset, synchronous, active-low
- TICK  in  1  1 Hz enable, one CP cycle wide
- SET_EN  in  1  setting mode; button inputs are ignored when low
- SEL  in  $clog2(ALARM_N+1)  adjust/readback target: 0 = time, k = alarm k-1; out-of-range values select nothing
- H_UP, H_DOWN, M_UP, M_DOWN  in  1 each  debounced single-cycle pulses
- S_CLR  in  1  pulse; clears seconds to 00 (time target only)
- AL_ON  in  ALARM_N  per-channel arm
- STOP, SNOOZE  in  1 each  single-cycle pulses; apply to all channels
- Q_H, Q_M, Q_S  out  8 each  BCD time (tens in [7:4], units in [3:0])
- A_H, A_M  out  8 each  BCD alarm time of channel SEL-1; 00 when SEL=0 or out of range
- RING  out  ALARM_N  per-channel ringing
- ALARM  out  1  OR of RING
- TC_D  out  1  day-wrap pulse
- CHIME  out  1  hourly pips (see Configuration)

## Operation
- BCD ranges: seconds and minutes 00..59, hours 00..23. All fields are pure BCD; no binary intermediate is visible on any output.
- Time freeze: time advances on TICK except when SET_EN=1 and SEL=0. In that condition TICK is dropped and not queued.
- Adjust (SET_EN=1): applies to the target selected by SEL.
  - H_UP: hour 23→00. H_DOWN: hour 00→23. M_UP: minute 59→00. M_DOWN: minute 00→59.
  - Minute adjust never carries into the hour.
  - UP and DOWN for the same field in the same cycle: no change.
  - S_CLR: seconds ← 00, no carry. Ignored when SEL≠0.
- Adjustment never triggers an alarm. A match is evaluated only on a TICK advance.
- Channel FSM, per channel k, states IDLE, RINGING, SNOOZED:
  - IDLE→RINGING: TICK advances time to HH:MM:00 equal to alarm k, and AL_ON[k]=1.
  - RINGING→IDLE: STOP, or RING_S TICKs counted since entry.
  - RINGING→SNOOZED: SNOOZE. The snooze target is the current HH:MM + SNOOZE_M minutes, with minute carry into hour and hour wrap 23→00.
  - SNOOZED→RINGING: TICK advances time to snooze target :00. The ring counter restarts.
  - SNOOZED→IDLE: STOP.
  - Any state→IDLE: AL_ON[k]=0. This overrides all other transitions in the same cycle.
  - STOP and SNOOZE in the same cycle: STOP wins.
  - Editing alarm k while SNOOZED leaves the snooze target unchanged.
  - Alarm match and snooze target match in the same TICK: the channel rings once.
- RING[k] = (state==RINGING).
- Reset (CR=0 at a CP edge):
  - Q = 00:00:00.
  - All alarms = 00:00.
  - All channels IDLE; ring counters = 0.
  - RING = 0, ALARM = 0, TC_D = 0, CHIME = 0.
  - Reset mid-ring or mid-snooze discards all snooze state.

## Timing
- Q_* update on the CP edge following the TICK cycle (1-cycle latency). Adjust pulses also take effect 1 cycle later.
- RING[k] rises in the same cycle Q first shows the matching HH:MM:00.
- Auto-stop: RING[k] falls on the cycle after the RING_S-th TICK counted in RINGING, so it stays high for exactly RING_S seconds.
- STOP/SNOOZE: RING falls 1 cycle after the pulse.
- TC_D: high for exactly 1 cycle, coincident with the first cycle Q shows 00:00:00 after an advance from 23:59:59. Never asserted by adjustment.
- A_H/A_M: registered; they follow a SEL change or an alarm edit with 1-cycle latency.
- ALARM: combinational OR of registered RING.

## Configuration
- HOURLY_CHIME_EN defined:
  - CHIME is registered and high while Q_M=59 and Q_S ∈ 55..59, then also high for Q=xx:00:00.
  - Forced 0 while SET_EN=1.
- HOURLY_CHIME_EN undefined:
  - CHIME port remains, tied to 0.
  - No chime logic is synthesised.

## Test plan
- Reset, then 3661 TICKs → Q=01:01:01. Preset 23:59:59 + 1 TICK → Q=00:00:00 and a 1-cycle TC_D pulse.
- Set alarm0 to 07:30 with AL_ON=0001 and time 07:29:59. Apply 1 TICK → RING=0001 and ALARM=1. Apply 30 more TICKs with RING_S=30 → RING=0 after the 30th.
- Alarm ringing at 23:58:00, then SNOOZE → RING=0. Advance to 00:03:00 → RING=0001. Then STOP → RING=0.
- With SET_EN=1 and SEL=0: 10 TICKs → Q unchanged. H_DOWN at 00 → 23. H_UP and H_DOWN in the same cycle → no change. S_CLR at :47 → :00.
- With SET_EN=1 and SEL=2: M_UP at alarm1 = 10:59 → 10:00 and A_M=00. With SET_EN=1 and SEL=0, move time to 10:00:00 by adjust → no RING. Drop AL_ON[1] while RINGING → RING[1]=0 next cycle.
- With HOURLY_CHIME_EN defined: TICKs through 12:59:54..13:00:01 → CHIME high for 12:59:55..12:59:59 and 13:00:00 only. With the macro undefined → CHIME stays 0 throughout.
